cix_iter: RTL and testbench



---
 rtl/cix_iter.sv | 146 ++++++++++++++
 tb/tb_cix_iter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/cix_iter.sv
// Multi-cycle bit-count unit (CTO/CTZ/CLO/CLZ/PCNT/ZCNT). Scans a 2**STEP-bit chunk per clock.
// Define CIX_ITER_EARLY_EN to end leading/trailing scans at the first mismatching chunk.
module cix_iter #(
   parameter int ORDER = 3,
   parameter int STEP  = 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [2:0]            op,
   input  logic [2**ORDER-1:0]   in,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ORDER:0]        out,
   output logic                  zero
);

   localparam int W  = 2**ORDER;
   localparam int C  = 2**STEP;
   localparam int N  = W / C;
   localparam int IW = ORDER - STEP + 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   // Operation class kept after capture; op[0] is folded into the operand inversion.
   localparam logic [1:0] K_RSVD  = 2'b00;
   localparam logic [1:0] K_TRAIL = 2'b01;
   localparam logic [1:0] K_LEAD  = 2'b10;
   localparam logic [1:0] K_POP   = 2'b11;

   state_t          state;
   logic [1:0]      kind_q;
   logic [W-1:0]    data_q;
   logic [ORDER:0]  acc;
   logic [IW-1:0]   idx;
   logic            term;
   logic            fin;

   logic [IW-1:0]   sel;
   logic [C-1:0]    chunk;
   logic [ORDER:0]  run_len;
   logic [ORDER:0]  pop;
   logic [ORDER:0]  add;
   logic            mismatch;
   logic            last;

   function automatic logic [ORDER:0] pop_f(input logic [C-1:0] c);
      logic [ORDER:0] cnt;
      cnt = '0;
      for (int i = 0; i < C; i++) cnt = cnt + (ORDER+1)'(c[i]);
      return cnt;
   endfunction

   // Length of the run of ones starting at the scan-side edge of the chunk.
   function automatic logic [ORDER:0] run_f(input logic [C-1:0] c, input logic from_msb);
      logic [ORDER:0] cnt;
      logic           stop;
      logic           b;
      cnt  = '0;
      stop = 1'b0;
      for (int i = 0; i < C; i++) begin
         b = from_msb ? c[C-1-i] : c[i];
         if (!stop && b) cnt = cnt + 1'b1;
         else            stop = 1'b1;
      end
      return cnt;
   endfunction

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      sel      = (kind_q == K_LEAD) ? IW'(N-1) - idx : idx;
      chunk    = data_q[int'(sel)*C +: C];
      pop      = pop_f(chunk);
      run_len  = run_f(chunk, kind_q == K_LEAD);
      mismatch = (run_len != (ORDER+1)'(C));
      last     = (idx == IW'(N-1));
      add      = '0;
      if (kind_q == K_POP) add = pop;
      else if (!term)      add = run_len;
   end

   // NOTE: all state is updated with non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out       <= '0;
         zero      <= 1'b0;
         kind_q    <= K_RSVD;
         data_q    <= '0;
         acc       <= '0;
         idx       <= '0;
         term      <= 1'b0;
         fin       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  kind_q   <= op[2:1];
                  data_q   <= op[0] ? ~in : in;
                  acc      <= '0;
                  idx      <= '0;
                  term     <= 1'b0;
                  fin      <= 1'b0;
                  in_ready <= 1'b0;
                  state    <= RUN;
               end
            end
            RUN: begin
               if (fin) begin
                  out       <= acc;
                  zero      <= (acc == (ORDER+1)'(W));
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else if (kind_q == K_RSVD) begin
                  fin <= 1'b1;
               end else begin
                  acc <= acc + add;
                  idx <= idx + IW'(1);
                  if (mismatch && kind_q != K_POP) term <= 1'b1;
`ifdef CIX_ITER_EARLY_EN
                  if (last || (mismatch && kind_q != K_POP)) fin <= 1'b1;
`else
                  if (last) fin <= 1'b1;
`endif
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // K_TRAIL only names the encoding; trailing scan is the non-leading default above.
   logic unused_kind;
   assign unused_kind = (K_TRAIL == 2'b01);

endmodule

// File: tb/tb_cix_iter.sv
// Self-checking bench for cix_iter (ORDER=3, STEP=1): directed plan plus random ops
// against a bit-level reference model of the count and latency rules.
module tb_cix_iter;

   localparam int ORDER = 3;
   localparam int STEP  = 1;
   localparam int W     = 2**ORDER;
   localparam int C     = 2**STEP;
   localparam int N     = W / C;

   logic             clock = 1'b0;
   logic             reset;
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       op;
   logic [W-1:0]     in;
   logic             out_valid;
   logic             out_ready;
   logic [ORDER:0]   out;
   logic             zero;

   int n_checks = 0;
   int n_fail   = 0;

   cix_iter #(.ORDER(ORDER), .STEP(STEP)) dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .in        (in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .zero      (zero)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference count straight from the op definitions, scanning the whole operand bit by bit.
   function automatic int model_cnt(input logic [2:0] o, input logic [W-1:0] v);
      int cnt;
      cnt = 0;
      case (o)
         3'b010: for (int i = 0; i < W; i++) begin if (v[i])       cnt++; else break; end
         3'b011: for (int i = 0; i < W; i++) begin if (!v[i])      cnt++; else break; end
         3'b100: for (int i = W-1; i >= 0; i--) begin if (v[i])   cnt++; else break; end
         3'b101: for (int i = W-1; i >= 0; i--) begin if (!v[i])  cnt++; else break; end
         3'b110: for (int i = 0; i < W; i++) if (v[i])  cnt++;
         3'b111: for (int i = 0; i < W; i++) if (!v[i]) cnt++;
         default: cnt = 0;
      endcase
      return cnt;
   endfunction

   // Number of RUN cycles; the first mismatching bit sits in chunk cnt/C from the scan edge.
   function automatic int model_k(input logic [2:0] o, input int cnt);
      if (o[2:1] == 2'b00) return 1;
      if (o[2:1] == 2'b11) return N;
`ifdef CIX_ITER_EARLY_EN
      return (cnt == W) ? N : cnt / C + 1;
`else
      return (cnt == W) ? N : N;
`endif
   endfunction

   task automatic run_op(input logic [2:0] o, input logic [W-1:0] v, input int hold);
      int             exp_cnt;
      int             exp_k;
      int             lat;
      logic [ORDER:0] held_out;
      logic           held_zero;
      exp_cnt = model_cnt(o, v);
      exp_k   = model_k(o, exp_cnt);
      check("in_ready_idle", in_ready, 1);
      in_valid = 1'b1;
      op       = o;
      in       = v;
      @(posedge clock); #1;
      in_valid = 1'b0;
      op       = 3'($urandom);
      in       = W'($urandom);
      check("in_ready_busy", in_ready, 0);
      lat = 0;
      while (!out_valid && lat < 64) begin
         @(posedge clock); #1;
         lat++;
      end
      check("latency", lat, exp_k + 1);
      check("out", out, exp_cnt);
      check("zero", zero, (exp_cnt == W) ? 1 : 0);
      held_out  = out;
      held_zero = zero;
      for (int h = 0; h < hold; h++) begin
         in_valid = 1'b1;
         op       = 3'b110;
         in       = ~v;
         @(posedge clock); #1;
         check("hold_valid", out_valid, 1);
         check("hold_out", out, held_out);
         check("hold_zero", zero, held_zero);
         check("hold_in_ready", in_ready, 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clock); #1;
      out_ready = 1'b0;
      check("post_valid", out_valid, 0);
      check("post_in_ready", in_ready, 1);
   endtask

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      op        = 3'b000;
      in        = '0;
      repeat (2) @(posedge clock);
      #1;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out", out, 0);
      check("rst_zero", zero, 0);
      reset = 1'b0;
      @(posedge clock); #1;

      // Directed plan
      run_op(3'b011, 8'h08, 0);   // CTZ -> 3
      run_op(3'b110, 8'hB5, 0);   // PCNT -> 5
      run_op(3'b111, 8'h00, 0);   // ZCNT -> 8, zero
      run_op(3'b100, 8'hFF, 0);   // CLO -> 8, zero
      run_op(3'b101, 8'h01, 0);   // CLZ -> 7
      run_op(3'b010, 8'h03, 0);   // CTO -> 2
      run_op(3'b010, 8'hC7, 3);   // backpressure with ignored in_valid
      run_op(3'b001, 8'h5A, 0);   // reserved
      run_op(3'b000, 8'hFF, 1);   // reserved

      // Reset on the second RUN cycle of a PCNT
      in_valid = 1'b1;
      op       = 3'b110;
      in       = 8'hB5;
      @(posedge clock); #1;
      in_valid = 1'b0;
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_in_ready", in_ready, 1);
      check("mid_rst_out", out, 0);
      check("mid_rst_zero", zero, 0);
      repeat (6) @(posedge clock);
      #1;
      check("mid_rst_no_result", out_valid, 0);
      run_op(3'b011, 8'h00, 0);   // CTZ -> 8, zero

      // Random operations
      for (int r = 0; r < 40; r++)
         run_op(3'($urandom), W'($urandom), int'($urandom_range(0, 2)));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
